// File: rtl/ls_pilot_sig_capture.sv
// Pilot-signal input port: synchroniser, debounce, edge capture,
// interrupt masking and a saturating event counter on Avalon-MM.
module ls_pilot_sig_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_RISE = 3'd1;
  localparam logic [2:0] A_MASK = 3'd2;
  localparam logic [2:0] A_CAP  = 3'd3;
  localparam logic [2:0] A_FALL = 3'd4;
  localparam logic [2:0] A_DEB  = 3'd5;
  localparam logic [2:0] A_EVT  = 3'd6;
  localparam logic [2:0] A_ID   = 3'd7;

  localparam logic [31:0] ID_VAL =
    {16'h5A17, 8'(SYNC_STAGES), 8'(WIDTH)};

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync_w;
  logic [WIDTH-1:0][DEBOUNCE_W-1:0]  deb_cnt;
  logic [WIDTH-1:0]                  filt;
  logic [WIDTH-1:0]                  filt_d;
  logic [WIDTH-1:0]                  rise_en;
  logic [WIDTH-1:0]                  fall_en;
  logic [WIDTH-1:0]                  irq_mask;
  logic [WIDTH-1:0]                  edge_cap;
  logic [DEBOUNCE_W-1:0]             deb_len;
  logic [CNT_W-1:0]                  evt_cnt;

  logic                              wr_en;
  logic [WIDTH-1:0]                  wr_bits;
  logic [WIDTH-1:0]                  clr_mask;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  fall;
  logic [WIDTH-1:0]                  edge_hit;
  logic                              any_edge;
  logic [31:0]                       rd_mux;
  logic                              unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wr_bits   = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign sync_w    = sync_q[SYNC_STAGES-1];

  assign clr_mask  = (wr_en && address == A_CAP) ?
                     wr_bits : '0;
  assign rise      = filt & ~filt_d;
  assign fall      = ~filt & filt_d;
  assign edge_hit  = (rise & rise_en) | (fall & fall_en);
  assign any_edge  = |edge_hit;

  assign irq       = |(edge_cap & irq_mask);

  // Metastability chain: each line passes through SYNC_STAGES flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Per-bit debounce: level must hold DEB_LEN+1 cycles to be accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt <= '0;
      filt    <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_w[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == deb_len) begin
          filt[i]    <= sync_w[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEBOUNCE_W'(1);
        end
      end
    end
  end

  // Delayed filtered level for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_d <= '0;
    end else begin
      filt_d <= filt;
    end
  end

  // Software-writable control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_en  <= '0;
      fall_en  <= '0;
      irq_mask <= '0;
      deb_len  <= '0;
    end else if (wr_en) begin
      unique case (address)
        A_RISE:  rise_en  <= wr_bits;
        A_MASK:  irq_mask <= wr_bits;
        A_FALL:  fall_en  <= wr_bits;
        A_DEB:   deb_len  <= writedata[DEBOUNCE_W-1:0];
        default: ;
      endcase
    end
  end

  // Edge capture: new edges win over a coincident W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~clr_mask) | edge_hit;
    end
  end

  // Saturating event counter; one count per cycle with any edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_cnt <= '0;
    end else if (wr_en && address == A_EVT) begin
      evt_cnt <= any_edge ? CNT_W'(1) : '0;
    end else if (any_edge && evt_cnt != '1) begin
      evt_cnt <= evt_cnt + CNT_W'(1);
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rd_mux = '0;
    unique case (address)
      A_DATA: rd_mux[WIDTH-1:0]      = filt;
      A_RISE: rd_mux[WIDTH-1:0]      = rise_en;
      A_MASK: rd_mux[WIDTH-1:0]      = irq_mask;
      A_CAP:  rd_mux[WIDTH-1:0]      = edge_cap;
      A_FALL: rd_mux[WIDTH-1:0]      = fall_en;
      A_DEB:  rd_mux[DEBOUNCE_W-1:0] = deb_len;
      A_EVT:  rd_mux[CNT_W-1:0]      = evt_cnt;
      A_ID:   rd_mux                 = ID_VAL;
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, independent of chipselect.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_ls_pilot_sig_capture.sv
// Bench for ls_pilot_sig_capture: register reads checked
// against a queue of expected values.
module tb_ls_pilot_sig_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  ls_pilot_sig_capture #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .DEBOUNCE_W(8),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [2:0] a,
                    input logic [31:0] e,
                    input string t);
    address = a;
    exp_q.push_back(e);
    tag_q.push_back(t);
    tick();
    chk(tag_q.pop_front(), readdata, exp_q.pop_front());
  endtask

  initial begin
    reset      = 1'b1;
    address    = 3'd7;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    idle(2);
    chk("rst_rdata", readdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    for (int a = 0; a < 7; a++) begin
      rd(3'(a), 32'h0, $sformatf("rst_reg%0d", a));
    end

    // Basic rising edge, latency to capture/irq/DATA
    wr(3'd1, 32'hFF);
    wr(3'd2, 32'h01);
    address = 3'd0;
    in_port = 8'h01;
    idle(3);
    chk("lat_irq_e3", {31'h0, irq}, 32'h0);
    chk("lat_data_e3", readdata, 32'h0);
    tick();
    chk("lat_irq_e4", {31'h0, irq}, 32'h1);
    chk("lat_data_e4", readdata, 32'h1);
    rd(3'd3, 32'h01, "cap_rise");
    rd(3'd6, 32'h01, "evt_one");
    wr(3'd3, 32'h01);
    chk("w1c_irq", {31'h0, irq}, 32'h0);
    rd(3'd3, 32'h00, "w1c_cap");

    // Falling-edge only on bit 7
    wr(3'd1, 32'h00);
    wr(3'd4, 32'h80);
    wr(3'd6, 32'h00);
    in_port = 8'h81;
    idle(6);
    rd(3'd3, 32'h00, "no_rise_cap");
    in_port = 8'h01;
    idle(6);
    rd(3'd3, 32'h80, "fall_cap");
    rd(3'd0, 32'h01, "fall_data");
    wr(3'd2, 32'h80);
    chk("fall_irq", {31'h0, irq}, 32'h1);
    wr(3'd3, 32'hFF);
    wr(3'd6, 32'h00);
    wr(3'd1, 32'h80);
    in_port = 8'h81;
    idle(6);
    in_port = 8'h01;
    idle(6);
    rd(3'd3, 32'h80, "both_cap");
    rd(3'd6, 32'h02, "both_evt");

    // Debounce length 3
    wr(3'd1, 32'hFF);
    wr(3'd4, 32'h00);
    wr(3'd2, 32'h01);
    wr(3'd5, 32'h03);
    rd(3'd5, 32'h03, "deb_len_rb");
    in_port = 8'h00;
    idle(10);
    wr(3'd3, 32'hFF);
    wr(3'd6, 32'h00);
    in_port = 8'h01;
    idle(3);
    in_port = 8'h00;
    idle(10);
    rd(3'd0, 32'h00, "p3_data");
    rd(3'd3, 32'h00, "p3_cap");
    rd(3'd6, 32'h00, "p3_evt");
    address = 3'd0;
    in_port = 8'h01;
    idle(4);
    in_port = 8'h00;
    idle(2);
    chk("p4_data_e6", readdata, 32'h0);
    tick();
    chk("p4_data_e7", readdata, 32'h1);
    chk("p4_irq_e7", {31'h0, irq}, 32'h1);
    idle(10);
    rd(3'd3, 32'h01, "p4_cap");
    rd(3'd6, 32'h01, "p4_evt");
    rd(3'd0, 32'h00, "p4_low");

    // Coincident edge and clear
    wr(3'd5, 32'h00);
    wr(3'd3, 32'hFF);
    in_port = 8'h04;
    idle(3);
    wr(3'd3, 32'h04);
    rd(3'd3, 32'h04, "w1c_race");
    wr(3'd3, 32'h04);
    rd(3'd3, 32'h00, "w1c_after");
    in_port = 8'h0C;
    idle(3);
    wr(3'd6, 32'h00);
    rd(3'd6, 32'h01, "clr_race");

    // Counting and saturation
    wr(3'd4, 32'hFF);
    wr(3'd6, 32'h00);
    for (int i = 0; i < 10; i++) begin
      in_port ^= 8'h01;
      tick();
    end
    idle(6);
    rd(3'd6, 32'd10, "evt_ten");
    for (int i = 0; i < 65540; i++) begin
      in_port ^= 8'h01;
      tick();
    end
    idle(6);
    rd(3'd6, 32'hFFFF, "evt_sat");
    for (int i = 0; i < 5; i++) begin
      in_port ^= 8'h01;
      tick();
    end
    idle(6);
    rd(3'd6, 32'hFFFF, "evt_hold");

    // Reset in the middle of a debounce
    wr(3'd2, 32'hFF);
    chk("pre_rst_irq", {31'h0, irq}, 32'h1);
    wr(3'd5, 32'd10);
    in_port ^= 8'h10;
    idle(5);
    reset   = 1'b1;
    address = 3'd7;
    tick();
    chk("mid_rst_rdata", readdata, 32'h0);
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    for (int a = 1; a < 7; a++) begin
      rd(3'(a), 32'h0, $sformatf("post_rst%0d", a));
    end
    rd(3'd7, 32'h5A170208, "id");
    chk("post_rst_irq", {31'h0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
